// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-flop synchronizer, debounce counter and 4-state FSM.
// Define PB_LONG_PRESS_EN to build the hold counter that drives long_press.
//
// state        | meaning
// IDLE         | debounced level released, raw agrees
// PRESS_WAIT   | raw pressed, counting stable cycles before accepting press
// HELD         | debounced level pressed, raw agrees
// RELEASE_WAIT | raw released, counting stable cycles before accepting release
module pb_debounce #(
    parameter int DB_CYC     = 50000,
    parameter int LONG_CYC   = 50000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic PB,
    output logic pb_lvl,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int CW = $clog2(DB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, sync2, raw;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lvl_nxt, pressed_nxt, released_nxt;

    if (LONG_CYC <= DB_CYC) begin : g_bad_long_cyc
        $error("pb_debounce: LONG_CYC must exceed DB_CYC");
    end

    // Reset loads the idle pin level so raw reads "not pressed" straight away.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= PB;
            sync2 <= sync1;
        end
    end

    assign raw = sync2 ^ ACTIVE_LOW;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        lvl_nxt      = pb_lvl;
        pressed_nxt  = 1'b0;
        released_nxt = 1'b0;
        if (raw != pb_lvl) begin
            cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
        end
        case (state)
            IDLE: begin
                if (raw) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!raw) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = HELD;
                    lvl_nxt     = 1'b1;
                    pressed_nxt = 1'b1;
                    cnt_nxt     = '0;
                end
            end
            HELD: begin
                if (!raw) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (raw) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    lvl_nxt      = 1'b0;
                    released_nxt = 1'b1;
                    cnt_nxt      = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pb_lvl   <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pb_lvl   <= lvl_nxt;
            pressed  <= pressed_nxt;
            released <= released_nxt;
        end
    end

`ifdef PB_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);

    logic [HW-1:0] hold;

    // Counts only while pb_lvl is high, so an accepted release freezes it short of HOLD_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (pressed_nxt) begin
                hold <= '0;
            end else if (pb_lvl && hold != HOLD_MAX) begin
                hold       <= hold + HW'(1);
                long_press <= (hold == HOLD_MAX - HW'(1));
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Randomized and directed bench for pb_debounce against a run-length model of the debounce rules.
module tb_pb_debounce;

    localparam int DB_CYC     = 4;
    localparam int LONG_CYC   = 20;
    localparam bit ACTIVE_LOW = 1'b1;
`ifdef PB_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic PB  = 1'b1;
    logic pb_lvl, pressed, released, long_press;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int p_cnt = 0, r_cnt = 0, l_cnt = 0;
    int p0, r0, l0;

    pb_debounce #(
        .DB_CYC    (DB_CYC),
        .LONG_CYC  (LONG_CYC),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PB        (PB),
        .pb_lvl    (pb_lvl),
        .pressed   (pressed),
        .released  (released),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Model: pin history delayed two edges, then a run of DB_CYC differing samples flips the level.
    bit m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0;
    bit e_p = 1'b0, e_r = 1'b0, e_l = 1'b0;
    int m_run = 0, m_age = 0;

    always @(posedge clk) begin
        bit m_raw;
        if (rst) begin
            m_s1 = ACTIVE_LOW; m_s2 = ACTIVE_LOW; m_lvl = 1'b0;
            m_run = 0; m_age = 0;
            e_p = 1'b0; e_r = 1'b0; e_l = 1'b0;
        end else begin
            m_raw = m_s2 ^ ACTIVE_LOW;
            e_p = 1'b0; e_r = 1'b0; e_l = 1'b0;
            if (LONG_EN && m_lvl && m_age < LONG_CYC) begin
                m_age++;
                if (m_age == LONG_CYC) e_l = 1'b1;
            end
            if (m_raw != m_lvl) begin
                m_run++;
                if (m_run == DB_CYC) begin
                    m_lvl = m_raw;
                    m_run = 0;
                    if (m_raw) begin
                        e_p = 1'b1;
                        m_age = 0;
                    end else begin
                        e_r = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = PB;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pb_lvl", 32'(pb_lvl), 32'(m_lvl));
            chk("pressed", 32'(pressed), 32'(e_p));
            chk("released", 32'(released), 32'(e_r));
            chk("long_press", 32'(long_press), 32'(e_l));
            chk("press_release_overlap", 32'(pressed & released), 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (pressed === 1'b1) p_cnt++;
        if (released === 1'b1) r_cnt++;
        if (long_press === 1'b1) l_cnt++;
    end

    task automatic nedges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset idle
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_pb_lvl", 32'(pb_lvl), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_long", 32'(long_press), 32'd0);
        nedges(2);
        rst = 1'b0;
        nedges(100);
        chk("idle_lvl", 32'(pb_lvl), 32'd0);
        chk("idle_press_cnt", 32'(p_cnt), 32'd0);

        // clean press and release
        PB = 1'b0;
        nedges(5);
        chk("clean_pressed_early", 32'(pressed), 32'd0);
        chk("clean_lvl_early", 32'(pb_lvl), 32'd0);
        nedges(1);
        chk("clean_pressed", 32'(pressed), 32'd1);
        chk("clean_lvl", 32'(pb_lvl), 32'd1);
        nedges(1);
        chk("clean_pressed_once", 32'(pressed), 32'd0);
        nedges(10);
        PB = 1'b1;
        nedges(5);
        chk("clean_released_early", 32'(released), 32'd0);
        nedges(1);
        chk("clean_released", 32'(released), 32'd1);
        chk("clean_lvl_low", 32'(pb_lvl), 32'd0);
        nedges(1);
        chk("clean_released_once", 32'(released), 32'd0);
        nedges(10);

        // bounce, then settle pressed
        for (int i = 0; i < 6; i++) begin
            PB = ~PB;
            nedges(2);
        end
        p0 = p_cnt;
        PB = 1'b0;
        nedges(5);
        chk("bounce_pressed_early", 32'(pressed), 32'd0);
        nedges(1);
        chk("bounce_pressed", 32'(pressed), 32'd1);
        nedges(5);
        chk("bounce_one_press", 32'(p_cnt - p0), 32'd1);
        PB = 1'b1;
        nedges(10);

        // 3-cycle glitch
        p0 = p_cnt;
        PB = 1'b0;
        nedges(3);
        PB = 1'b1;
        nedges(10);
        chk("glitch_no_press", 32'(p_cnt - p0), 32'd0);
        chk("glitch_lvl", 32'(pb_lvl), 32'd0);

        // long press
        l0 = l_cnt;
        PB = 1'b0;
        nedges(6);
        chk("long_pressed", 32'(pressed), 32'd1);
        nedges(19);
        chk("long_early", 32'(long_press), 32'd0);
        nedges(1);
        chk("long_at_E20", 32'(long_press), 32'(LONG_EN));
        nedges(1);
        chk("long_after", 32'(long_press), 32'd0);
        nedges(13);
        PB = 1'b1;
        nedges(6);
        chk("long_released", 32'(released), 32'd1);
        chk("long_once", 32'(l_cnt - l0), 32'(LONG_EN));
        nedges(5);

        // release before long
        l0 = l_cnt;
        PB = 1'b0;
        nedges(6);
        nedges(12);
        PB = 1'b1;
        nedges(30);
        chk("short_no_long", 32'(l_cnt - l0), 32'd0);

        // reset mid-hold, button held through reset
        PB = 1'b0;
        nedges(8);
        chk("mid_lvl_before", 32'(pb_lvl), 32'd1);
        r0 = r_cnt;
        rst = 1'b1;
        nedges(1);
        chk("mid_rst_lvl", 32'(pb_lvl), 32'd0);
        chk("mid_rst_released", 32'(released), 32'd0);
        chk("mid_rst_pressed", 32'(pressed), 32'd0);
        nedges(1);
        rst = 1'b0;
        nedges(5);
        chk("mid_repress_early", 32'(pressed), 32'd0);
        nedges(1);
        chk("mid_repress", 32'(pressed), 32'd1);
        chk("mid_no_release", 32'(r_cnt - r0), 32'd0);
        PB = 1'b1;
        nedges(10);

        // randomized pin activity with occasional resets
        for (int k = 0; k < 250; k++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst = 1'b1;
                nedges($urandom_range(1, 3));
                rst = 1'b0;
            end else begin
                PB = ~PB;
                if (r < 10) nedges($urandom_range(1, 5));
                else nedges($urandom_range(4, 30));
            end
        end
        PB = 1'b1;
        nedges(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
